// File: rtl/icache_line.sv
// Direct-mapped instruction cache between ifetch and memctrl: 1-cycle hits,
// critical-word-first line refill, cancel/drain and whole-cache invalidate.
module icache_line #(
    parameter int INDEX_WIDTH  = 3,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    input  logic        cancel,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t                     state_reg, state_next;
    logic [LINES-1:0]           valid_reg;
    logic [TAG_WIDTH-1:0]       tag_mem [LINES];
    logic [31:0]                data_mem [LINES*WORDS];
    logic [31:0]                rd_data_reg;
    logic [31:0]                resp_word_reg;
    logic                       resp_from_ram_reg;
    logic                       resp_valid_reg;
    logic                       mem_req_reg, mem_req_next;
    logic [31:0]                mem_addr_reg;
    logic [31:0]                hit_count_reg, miss_count_reg;
    logic                       poisoned_reg;
    logic [TAG_WIDTH-1:0]       tag_lat_reg;
    logic [INDEX_WIDTH-1:0]     index_lat_reg;
    logic [OFFSET_WIDTH-1:0]    req_off_reg, fill_ptr_reg, fill_ptr_inc;

    logic [TAG_WIDTH-1:0]       req_tag;
    logic [INDEX_WIDTH-1:0]     req_index;
    logic [OFFSET_WIDTH-1:0]    req_offset;
    logic                       lookup, line_hit, lookup_hit, lookup_miss, fill_last;
    logic                       fill_write, fill_done, issue_next;
    logic                       unused_pc_bits;

    assign req_tag        = req_pc[31 -: TAG_WIDTH];
    assign req_index      = req_pc[OFFSET_WIDTH+2 +: INDEX_WIDTH];
    assign req_offset     = req_pc[2 +: OFFSET_WIDTH];
    assign unused_pc_bits = ^req_pc[1:0];

    assign lookup       = (state_reg == IDLE) && req_valid && !cancel;
    assign line_hit     = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
    assign lookup_hit   = lookup && line_hit;
    assign lookup_miss  = lookup && !line_hit;
    assign fill_ptr_inc = fill_ptr_reg + OFFSET_WIDTH'(1);
    // Fill started at the requested offset, so it ends just before it.
    assign fill_last    = (fill_ptr_inc == req_off_reg);

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_inst  = resp_from_ram_reg ? rd_data_reg : resp_word_reg;
    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    always_comb begin
        state_next   = state_reg;
        mem_req_next = mem_req_reg;
        fill_write   = 1'b0;
        fill_done    = 1'b0;
        issue_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (lookup_miss) begin
                    state_next   = REQ;
                    mem_req_next = 1'b1;
                end
            end
            REQ: begin
                if (mem_grant) begin
                    state_next   = cancel ? DRAIN : WAIT;
                    mem_req_next = 1'b0;
                end else if (cancel) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                end
            end
            WAIT: begin
                if (cancel) begin
                    state_next = mem_valid ? IDLE : DRAIN;
                end else if (mem_valid) begin
                    fill_write = 1'b1;
                    if (fill_last) begin
                        fill_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        issue_next   = 1'b1;
                        mem_req_next = 1'b1;
                        state_next   = REQ;
                    end
                end
            end
            DRAIN: begin
                if (mem_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            mem_req_reg       <= 1'b0;
            mem_addr_reg      <= '0;
            resp_valid_reg    <= 1'b0;
            resp_word_reg     <= '0;
            resp_from_ram_reg <= 1'b0;
            hit_count_reg     <= '0;
            miss_count_reg    <= '0;
            poisoned_reg      <= 1'b0;
            tag_lat_reg       <= '0;
            index_lat_reg     <= '0;
            req_off_reg       <= '0;
            fill_ptr_reg      <= '0;
        end else if (rdy) begin
            state_reg      <= state_next;
            mem_req_reg    <= mem_req_next;
            resp_valid_reg <= lookup_hit || fill_done;
            if (lookup_hit) begin
                hit_count_reg     <= hit_count_reg + 32'd1;
                resp_from_ram_reg <= 1'b1;
            end
            if (lookup_miss) begin
                miss_count_reg <= miss_count_reg + 32'd1;
                tag_lat_reg    <= req_tag;
                index_lat_reg  <= req_index;
                req_off_reg    <= req_offset;
                fill_ptr_reg   <= req_offset;
                mem_addr_reg   <= {req_pc[31:2], 2'b00};
                poisoned_reg   <= invalidate;
            end else if (invalidate && state_reg != IDLE) begin
                poisoned_reg <= 1'b1;
            end
            if (fill_write) begin
                fill_ptr_reg <= fill_ptr_inc;
                if (fill_ptr_reg == req_off_reg) begin
                    resp_word_reg     <= mem_data;
                    resp_from_ram_reg <= 1'b0;
                end
            end
            if (issue_next) mem_addr_reg <= {tag_lat_reg, index_lat_reg, fill_ptr_inc, 2'b00};
        end
    end

    // Line storage carries no reset; validity alone decides hits.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (fill_write) data_mem[{index_lat_reg, fill_ptr_reg}] <= mem_data;
            if (lookup_hit) rd_data_reg <= data_mem[{req_index, req_offset}];
            if (fill_done) tag_mem[index_lat_reg] <= tag_lat_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (rdy) begin
                    if (invalidate)
                        valid_reg[gi] <= 1'b0;
                    else if (lookup_miss && req_index == INDEX_WIDTH'(gi))
                        valid_reg[gi] <= 1'b0;
                    else if (fill_done && !poisoned_reg && index_lat_reg == INDEX_WIDTH'(gi))
                        valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate
endmodule

// File: doc/icache_line.md
Name: icache_line

Overview:
- Direct-mapped instruction cache with parametrised depth and multi-word lines. Sits between ifetch and memctrl.
- On a miss it refills a whole line with one memctrl word request per word, critical word first.
- Supports cancellation of an in-flight fetch (branch redirect) and whole-cache invalidation (fence.i).
- Exposes wrapping hit/miss counters for performance measurement.

Parameters:
- INDEX_WIDTH, 3: number of lines = 2^INDEX_WIDTH.
- OFFSET_WIDTH, 2: words per line = 2^OFFSET_WIDTH, 32-bit words; must be >= 1.
- TAG_WIDTH: 30-INDEX_WIDTH-OFFSET_WIDTH, derived; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; low = hold all state, no output changes
- req_valid  in  1  ifetch lookup request, one-cycle pulse, honoured only when req_ready=1
- req_pc  in  32  fetch address, byte address; word returned is pc[31:2]
- req_ready  out  1  cache idle and able to accept a request
- resp_valid  out  1  one-cycle pulse, resp_inst valid
- resp_inst  out  32  aligned instruction word containing req_pc
- cancel  in  1  ifetch redirect; discard current request
- invalidate  in  1  clear all valid bits (fence.i)
- mem_req  out  1  word read request to memctrl
- mem_addr  out  32  word-aligned read address
- mem_grant  in  1  memctrl accepted mem_req this cycle
- mem_valid  in  1  mem_data valid for the last granted request
- mem_data  in  32  returned word
- hit_count  out  32  wrapping count of lookup hits
- miss_count  out  32  wrapping count of lookup misses

Behaviour:
- Reset:
  - Synchronous, active-high on rst; clock is clk. rst has priority over rdy.
  - Reset values: all valid bits 0, state IDLE, req_ready 1, resp_valid 0, resp_inst 0, mem_req 0, mem_addr 0, hit_count 0, miss_count 0.
- Address split:
  - word offset = pc[OFFSET_WIDTH+1:2]
  - index = pc[OFFSET_WIDTH+INDEX_WIDTH+1:OFFSET_WIDTH+2]
  - tag = upper TAG_WIDTH bits; pc[1:0] ignored.
- rdy low: every register holds, including counters and mem_req. Inputs are ignored that cycle.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE, req_valid=1 and cancel=0:
  - Hit (valid && tag match): next cycle resp_valid=1 with the stored word; hit_count+1; stay IDLE. Hit latency is 1 cycle.
  - Miss: miss_count+1; latch pc; fill pointer = requested word offset; mem_req=1, mem_addr = {tag, index, fill_ptr, 2'b00}; go REQ; req_ready=0.
- REQ:
  - mem_req held with stable mem_addr until mem_grant.
  - On grant: mem_req=0 next cycle; go WAIT.
- WAIT, on mem_valid:
  - Write the word into the line at fill_ptr.
  - If fill_ptr equals the requested offset, capture it for response.
  - fill_ptr increments modulo line size (wraps within line).
  - If all 2^OFFSET_WIDTH words are written: mark the line valid (unless the poisoned flag is set), tag = latched tag, resp_valid=1 with the requested word next cycle, go IDLE, req_ready=1.
  - Otherwise re-issue mem_req for the next word and go REQ.
- Validity during refill: the line's valid bit is cleared at refill start. It is never valid while partially filled.
- cancel:
  - IDLE: a same-cycle req_valid is ignored; no counter change.
  - REQ without mem_grant that cycle: drop mem_req next cycle, go IDLE; line left invalid.
  - REQ with mem_grant the same cycle, or WAIT without mem_valid: go DRAIN.
  - WAIT with mem_valid the same cycle: the word is discarded; go IDLE.
  - No resp_valid is produced for a cancelled request.
- DRAIN: wait for mem_valid, discard the data, go IDLE. req_ready=0 until then.
- invalidate:
  - Clears all valid bits next cycle, in any state.
  - If a refill is in progress, set a sticky poisoned flag; that refill completes and responds normally but does not set its valid bit.
  - invalidate together with a hit lookup in IDLE: the lookup uses pre-invalidate state (hit returned), then the cache is invalid.
- resp_valid is never asserted in the same cycle as req_ready=0 due to a new miss.
- At most one outstanding memctrl word.
- Counters wrap 0xFFFFFFFF -> 0.

Test Plan:
- Cold miss, OFFSET_WIDTH=2, pc=0x00000008 -> mem_addr sequence 0x08, 0x0C, 0x00, 0x04; resp_inst = word returned for 0x08; miss_count=1.
- Same line refetch at pc=0x00000004 -> resp_valid 1 cycle later, no mem_req; hit_count=1.
- Conflict: pc=0x00000000 then pc=0x00000080 (INDEX_WIDTH=3) -> second misses and evicts; third fetch of 0x00000000 misses again; miss_count=3.
- cancel asserted while in WAIT (after grant for 0x08) -> DRAIN, mem_valid data dropped, no resp_valid, line 0 invalid; following fetch of 0x08 misses.
- invalidate during refill of 0x20 -> response still returned; immediate refetch of 0x20 misses.
- rdy held low 3 cycles in REQ -> mem_req and mem_addr unchanged, counters frozen; rst mid-WAIT -> all outputs at reset values next cycle.
